// File: rtl/rv_alu_issue_if.sv
// Issue-stage bus: instruction handshake, ALU drive/return and writeback report.
// master = instruction producer / ALU side, slave = rv_alu_issue.
interface rv_alu_issue_if #(
  parameter int unsigned XLEN = 16
);
  logic            instr_valid;
  logic            instr_ready;
  logic [31:0]     instr;
  logic [3:0]      alu_instruction_bits;
  logic [XLEN-1:0] alu_a;
  logic [XLEN-1:0] alu_b;
  logic [XLEN-1:0] alu_result;
  logic            wb_valid;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            illegal;

  modport master (
    output instr_valid, instr, alu_result,
    input  instr_ready, alu_instruction_bits, alu_a, alu_b,
           wb_valid, wb_rd, wb_data, illegal
  );

  modport slave (
    input  instr_valid, instr, alu_result,
    output instr_ready, alu_instruction_bits, alu_a, alu_b,
           wb_valid, wb_rd, wb_data, illegal
  );
endinterface

// File: rtl/rv_alu_issue.sv
// Issue/sequencer for an external alu_control+alu pair: decodes RV32 R-type
// add/sub/and/or, drives operands from a local register file, retires the result.
module rv_alu_issue #(
  parameter int unsigned XLEN  = 16,
  parameter int unsigned NREGS = 32
) (
  input  logic            clk,
  input  logic            rst,
  rv_alu_issue_if.slave   bus,
  input  logic            ld_en,
  input  logic [4:0]      ld_addr,
  input  logic [XLEN-1:0] ld_data,
  input  logic [4:0]      dbg_addr,
  output logic [XLEN-1:0] dbg_data
);

  localparam logic [6:0] OPC_OP = 7'b0110011;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WB} state_t;

  state_t          r_state;
  logic [XLEN-1:0] r_regs [NREGS];
  logic [3:0]      r_code;
  logic [XLEN-1:0] r_alu_a;
  logic [XLEN-1:0] r_alu_b;
  logic [4:0]      r_rd;
  logic            r_wb_valid;
  logic [4:0]      r_wb_rd;
  logic [XLEN-1:0] r_wb_data;
  logic            r_illegal;

  logic            w_accept;
  logic            w_legal;
  logic [3:0]      w_code;
  logic [4:0]      w_rs1;
  logic [4:0]      w_rs2;
  logic [XLEN-1:0] w_rs1_val;
  logic [XLEN-1:0] w_rs2_val;

  // Preload has priority over issue; ready is forced low while reset is applied.
  assign bus.instr_ready = (r_state == S_IDLE) && !ld_en && !rst;
  assign w_accept        = bus.instr_valid && bus.instr_ready;

  assign w_code = {bus.instr[30], bus.instr[14:12]};
  assign w_rs1  = bus.instr[19:15];
  assign w_rs2  = bus.instr[24:20];
  assign w_legal = (bus.instr[6:0] == OPC_OP) && !bus.instr[31] &&
                   (bus.instr[29:25] == 5'd0) &&
                   ((w_code == 4'b0000) || (w_code == 4'b1000) ||
                    (w_code == 4'b0111) || (w_code == 4'b0110));

  assign w_rs1_val = (w_rs1 == 5'd0) ? '0 : r_regs[w_rs1];
  assign w_rs2_val = (w_rs2 == 5'd0) ? '0 : r_regs[w_rs2];
  assign dbg_data  = (dbg_addr == 5'd0) ? '0 : r_regs[dbg_addr];

  assign bus.alu_instruction_bits = r_code;
  assign bus.alu_a                = r_alu_a;
  assign bus.alu_b                = r_alu_b;
  assign bus.wb_valid             = r_wb_valid;
  assign bus.wb_rd                = r_wb_rd;
  assign bus.wb_data              = r_wb_data;
  assign bus.illegal              = r_illegal;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
      r_code     <= '0;
      r_alu_a    <= '0;
      r_alu_b    <= '0;
      r_rd       <= '0;
      r_wb_valid <= 1'b0;
      r_wb_rd    <= '0;
      r_wb_data  <= '0;
      r_illegal  <= 1'b0;
    end else begin
      r_wb_valid <= 1'b0;
      r_illegal  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (w_legal) begin
              r_code  <= w_code;
              r_alu_a <= w_rs1_val;
              r_alu_b <= w_rs2_val;
              r_rd    <= bus.instr[11:7];
              r_state <= S_EXEC;
            end else begin
              r_illegal <= 1'b1;
            end
          end else if (ld_en && (ld_addr != 5'd0)) begin
            r_regs[ld_addr] <= ld_data;
          end
        end
        // ALU inputs are stable this cycle; capture its combinational result.
        S_EXEC: begin
          r_wb_data <= bus.alu_result;
          r_wb_rd   <= r_rd;
          if (r_rd != 5'd0) r_regs[r_rd] <= bus.alu_result;
          r_wb_valid <= 1'b1;
          r_state    <= S_WB;
        end
        S_WB:    r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rv_alu_issue.sv
// Directed self-checking bench for rv_alu_issue with a behavioural ALU stand-in.
module tb_rv_alu_issue;

  logic        clk = 1'b0;
  logic        rst;
  logic        ld_en;
  logic [4:0]  ld_addr;
  logic [15:0] ld_data;
  logic [4:0]  dbg_addr;
  logic [15:0] dbg_data;
  int          passed = 0;
  int          total  = 0;

  rv_alu_issue_if #(.XLEN(16)) bus ();

  rv_alu_issue #(.XLEN(16), .NREGS(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .ld_en    (ld_en),
    .ld_addr  (ld_addr),
    .ld_data  (ld_data),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  always #5 clk = ~clk;

  // Reference ALU: add / sub / and / or selected by {funct7[5], funct3}.
  always_comb begin
    case (bus.alu_instruction_bits)
      4'b0000: bus.alu_result = bus.alu_a + bus.alu_b;
      4'b1000: bus.alu_result = bus.alu_a - bus.alu_b;
      4'b0111: bus.alu_result = bus.alu_a & bus.alu_b;
      4'b0110: bus.alu_result = bus.alu_a | bus.alu_b;
      default: bus.alu_result = 16'h0000;
    endcase
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [4:0] a, input logic [15:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    step();
    ld_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; ld_en = 1'b0; ld_addr = '0; ld_data = '0; dbg_addr = '0;
    bus.instr_valid = 1'b0; bus.instr = '0;
    step(); step();
    total++;
    if ({bus.instr_ready, bus.wb_valid, bus.illegal, bus.alu_instruction_bits,
         bus.alu_a, bus.alu_b, bus.wb_rd, bus.wb_data} !== 62'd0)
      $display("FAIL reset_outputs got rdy=%b wbv=%b ill=%b code=%h a=%h b=%h rd=%h d=%h want all 0",
               bus.instr_ready, bus.wb_valid, bus.illegal, bus.alu_instruction_bits,
               bus.alu_a, bus.alu_b, bus.wb_rd, bus.wb_data);
    else passed++;
    rst = 1'b0;
    #1;
    total++;
    if (bus.instr_ready !== 1'b1)
      $display("FAIL reset_ready_after got %b want 1", bus.instr_ready);
    else passed++;
  endtask

  // Issue one legal R-type and check EXEC drive, WB report, regfile and hold.
  task automatic test_legal_issue(input string nm, input logic [31:0] ins,
                                  input logic [3:0] code, input logic [15:0] a,
                                  input logic [15:0] b, input logic [4:0] rd,
                                  input logic [15:0] res);
    logic [15:0] exp_rf;
    bus.instr_valid = 1'b1; bus.instr = ins;
    step();
    bus.instr_valid = 1'b0; bus.instr = 32'hDEADBEEF;
    total++;
    if ({bus.alu_instruction_bits, bus.alu_a, bus.alu_b, bus.wb_valid} !== {code, a, b, 1'b0})
      $display("FAIL %s_exec got code=%b a=%h b=%h wbv=%b want code=%b a=%h b=%h wbv=0",
               nm, bus.alu_instruction_bits, bus.alu_a, bus.alu_b, bus.wb_valid, code, a, b);
    else passed++;
    step();
    total++;
    if ({bus.wb_valid, bus.wb_rd, bus.wb_data} !== {1'b1, rd, res})
      $display("FAIL %s_wb got v=%b rd=%0d d=%h want v=1 rd=%0d d=%h",
               nm, bus.wb_valid, bus.wb_rd, bus.wb_data, rd, res);
    else passed++;
    dbg_addr = rd;
    #1;
    exp_rf = (rd == 5'd0) ? 16'h0000 : res;
    total++;
    if (dbg_data !== exp_rf)
      $display("FAIL %s_rf got %h want %h", nm, dbg_data, exp_rf);
    else passed++;
    step();
    total++;
    if ({bus.wb_valid, bus.wb_rd, bus.wb_data, bus.instr_ready} !== {1'b0, rd, res, 1'b1})
      $display("FAIL %s_hold got v=%b rd=%0d d=%h rdy=%b want v=0 rd=%0d d=%h rdy=1",
               nm, bus.wb_valid, bus.wb_rd, bus.wb_data, bus.instr_ready, rd, res);
    else passed++;
  endtask

  task automatic test_add();
    preload(5'd1, 16'd1);
    preload(5'd2, 16'd2);
    test_legal_issue("add", 32'h002081B3, 4'b0000, 16'd1, 16'd2, 5'd3, 16'd3);
  endtask

  task automatic test_sub();
    test_legal_issue("sub", 32'h40110233, 4'b1000, 16'd2, 16'd1, 5'd4, 16'd1);
    test_legal_issue("sub_wrap", 32'h40208233, 4'b1000, 16'd1, 16'd2, 5'd4, 16'hFFFF);
  endtask

  task automatic test_and_or();
    test_legal_issue("and", 32'h0020F2B3, 4'b0111, 16'd1, 16'd2, 5'd5, 16'd0);
    test_legal_issue("or", 32'h0020E333, 4'b0110, 16'd1, 16'd2, 5'd6, 16'd3);
  endtask

  task automatic test_illegal();
    logic [31:0] bad [2];
    bad[0] = 32'h0020C1B3;
    bad[1] = 32'h002081B7;
    for (int i = 0; i < 2; i++) begin
      bus.instr_valid = 1'b1; bus.instr = bad[i];
      step();
      bus.instr_valid = 1'b0;
      total++;
      if ({bus.illegal, bus.wb_valid, bus.alu_instruction_bits, bus.alu_a, bus.alu_b} !==
          {1'b1, 1'b0, 4'b0110, 16'd1, 16'd2})
        $display("FAIL illegal%0d_pulse got ill=%b wbv=%b code=%b a=%h b=%h want ill=1 wbv=0 code=0110 a=1 b=2",
                 i, bus.illegal, bus.wb_valid, bus.alu_instruction_bits, bus.alu_a, bus.alu_b);
      else passed++;
      step();
      total++;
      if ({bus.illegal, bus.wb_valid, bus.instr_ready} !== 3'b001)
        $display("FAIL illegal%0d_after got ill=%b wbv=%b rdy=%b want 0 0 1",
                 i, bus.illegal, bus.wb_valid, bus.instr_ready);
      else passed++;
    end
    dbg_addr = 5'd3;
    #1;
    total++;
    if (dbg_data !== 16'd3) $display("FAIL illegal_x3 got %h want 0003", dbg_data);
    else passed++;
  endtask

  task automatic test_x0_and_ld_block();
    test_legal_issue("add_x0", 32'h00208033, 4'b0000, 16'd1, 16'd2, 5'd0, 16'd3);
    // Offer sub x4,x2,x1 while preloading: it must wait for ld_en to drop.
    bus.instr_valid = 1'b1; bus.instr = 32'h40110233;
    ld_en = 1'b1; ld_addr = 5'd8; ld_data = 16'h0055;
    #1;
    for (int i = 0; i < 3; i++) begin
      total++;
      if ({bus.instr_ready, bus.alu_instruction_bits, bus.wb_valid} !== {1'b0, 4'b0000, 1'b0})
        $display("FAIL ld_block%0d got rdy=%b code=%b wbv=%b want rdy=0 code=0000 wbv=0",
                 i, bus.instr_ready, bus.alu_instruction_bits, bus.wb_valid);
      else passed++;
      step();
    end
    ld_en = 1'b0;
    #1;
    total++;
    if (bus.instr_ready !== 1'b1) $display("FAIL ld_release got rdy=%b want 1", bus.instr_ready);
    else passed++;
    step();
    bus.instr_valid = 1'b0;
    total++;
    if ({bus.alu_instruction_bits, bus.alu_a, bus.alu_b} !== {4'b1000, 16'd2, 16'd1})
      $display("FAIL ld_then_issue got code=%b a=%h b=%h want 1000 0002 0001",
               bus.alu_instruction_bits, bus.alu_a, bus.alu_b);
    else passed++;
    step();
    total++;
    if ({bus.wb_valid, bus.wb_rd, bus.wb_data} !== {1'b1, 5'd4, 16'd1})
      $display("FAIL ld_then_wb got v=%b rd=%0d d=%h want 1 4 0001",
               bus.wb_valid, bus.wb_rd, bus.wb_data);
    else passed++;
    dbg_addr = 5'd8;
    #1;
    total++;
    if (dbg_data !== 16'h0055) $display("FAIL preload_x8 got %h want 0055", dbg_data);
    else passed++;
    step();
  endtask

  task automatic test_reset_mid();
    logic [4:0] regs_chk [3];
    bus.instr_valid = 1'b1; bus.instr = 32'h002083B3;
    step();
    bus.instr_valid = 1'b0;
    rst = 1'b1;
    #1;
    total++;
    if (bus.instr_ready !== 1'b0) $display("FAIL rst_mid_ready got %b want 0", bus.instr_ready);
    else passed++;
    step();
    rst = 1'b0;
    #1;
    total++;
    if ({bus.wb_valid, bus.instr_ready} !== 2'b01)
      $display("FAIL rst_mid_after got wbv=%b rdy=%b want 0 1", bus.wb_valid, bus.instr_ready);
    else passed++;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (bus.wb_valid !== 1'b0) $display("FAIL rst_mid_wbv%0d got %b want 0", i, bus.wb_valid);
      else passed++;
    end
    regs_chk[0] = 5'd7; regs_chk[1] = 5'd1; regs_chk[2] = 5'd2;
    for (int i = 0; i < 3; i++) begin
      dbg_addr = regs_chk[i];
      #1;
      total++;
      if (dbg_data !== 16'h0000)
        $display("FAIL rst_mid_x%0d got %h want 0000", regs_chk[i], dbg_data);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_and_or();
    test_illegal();
    test_x0_and_ld_block();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got no completion want finish before 100000");
    $fatal(1, "timeout");
  end

endmodule
